// File: rtl/vga_scanout.sv
// 640x480@60 scanout for the 160x120x3 framebuffer: pixel timing from a 50 MHz clock,
// 4x upscaled fetch through a one-cycle synchronous read port, and a once-per-frame tick.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [14:0] rd_addr,
  input  logic [2:0]  rd_data,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        frame_start
);

  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        pix_en;
  logic        active;
  logic        hs_n;
  logic        vs_n;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [14:0] y_w;

  assign VGA_SYNC_N = 1'b1;
  assign pix_en     = VGA_CLK;

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) VGA_CLK <= 1'b0;
    else      VGA_CLK <= ~VGA_CLK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  // NOTE: every always_comb output is given a default first so no latch can be inferred.
  always_comb begin
    x       = hcount[9:2];
    y       = vcount[8:2];
    y_w     = {8'b0, y};
    active  = (hcount < H_VIS) && (vcount < V_VIS);
    hs_n    = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
    vs_n    = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
    rd_addr = '0;
    if (active) rd_addr = (y_w << 7) + (y_w << 5) + {7'b0, x};
  end

  // rd_data was fetched on the intervening pix_en=0 edge for the current counter position,
  // so colour, syncs and blank all describe the same pixel one pixel period late.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pix_en) begin
      VGA_HS      <= hs_n;
      VGA_VS      <= vs_n;
      VGA_BLANK_N <= active;
      VGA_R       <= {10{rd_data[2] & active}};
      VGA_G       <= {10{rd_data[1] & active}};
      VGA_B       <= {10{rd_data[0] & active}};
    end
  end

  // Counters sit at (0, V_ACTIVE) for two clocks; pulsing on the pix_en=0 half gives one clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_start <= 1'b0;
    else      frame_start <= !pix_en && (hcount == '0) && (vcount == V_VIS);
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout on a reduced raster; expected pins come from the
// elapsed clock count since reset release, mapped to raster positions arithmetically.
module tb_vga_scanout;

  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 48, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME_PIX = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data = 3'b0;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
  logic [9:0]  VGA_R, VGA_G, VGA_B;

  logic [2:0] mem [0:19199];
  bit         rand_data = 1'b1;

  int tests = 0, failed = 0;
  int n = 0;
  int fs_count, last_fs, hs_low, blank_hi, vs_low, last_hs_fall, red_cycles, max_addr;
  logic prev_hs;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  // Synchronous-read framebuffer; random garbage while the scanout is held in reset.
  always @(posedge clk) rd_data <= rand_data ? 3'($urandom) : mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s at n=%0d: observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  function automatic int pix_addr(input int h, input int v);
    return (v / 4) * 160 + (h / 4);
  endfunction

  task automatic check_reset();
    check("rst_vga_clk", 32'(VGA_CLK), 0);
    check("rst_hs", 32'(VGA_HS), 1);
    check("rst_vs", 32'(VGA_VS), 1);
    check("rst_blank_n", 32'(VGA_BLANK_N), 0);
    check("rst_rgb", {2'b0, VGA_R, VGA_G, VGA_B}, 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_sync_n", 32'(VGA_SYNC_N), 1);
  endtask

  // Pins after edge n show pixel (n-2)/2; the address bus shows counter position n/2.
  task automatic check_cycle();
    int c, ch, cv, p, h, v;
    logic act, cact, exp_hs, exp_vs;
    logic [2:0] px;
    check("vga_clk", 32'(VGA_CLK), n % 2);
    check("sync_n", 32'(VGA_SYNC_N), 1);
    c    = (n / 2) % FRAME_PIX;
    ch   = c % HT;
    cv   = c / HT;
    cact = (ch < HA) && (cv < VA);
    check("rd_addr", 32'(rd_addr), cact ? pix_addr(ch, cv) : 0);
    check("frame_start", 32'(frame_start), (n % 2 == 1 && c == VA * HT) ? 1 : 0);
    if (n < 2) begin
      act = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; px = 3'b0;
    end else begin
      p      = ((n - 2) / 2) % FRAME_PIX;
      h      = p % HT;
      v      = p / HT;
      act    = (h < HA) && (v < VA);
      exp_hs = !(h >= HA + HFP && h < HA + HFP + HSW);
      exp_vs = !(v >= VA + VFP && v < VA + VFP + VSW);
      px     = act ? mem[pix_addr(h, v)] : 3'b0;
    end
    check("hs", 32'(VGA_HS), 32'(exp_hs));
    check("vs", 32'(VGA_VS), 32'(exp_vs));
    check("blank_n", 32'(VGA_BLANK_N), 32'(act));
    check("r", 32'(VGA_R), 32'({10{px[2]}}));
    check("g", 32'(VGA_G), 32'({10{px[1]}}));
    check("b", 32'(VGA_B), 32'({10{px[0]}}));
  endtask

  task automatic measure();
    if (frame_start) begin
      fs_count++;
      if (last_fs < 0) check("fs_first", n, 2 * VA * HT + 1);
      else             check("fs_period", n - last_fs, 2 * FRAME_PIX);
      last_fs = n;
    end
    if (!VGA_HS) hs_low++;
    else if (hs_low != 0) begin check("hs_width", hs_low, 2 * HSW); hs_low = 0; end
    if (prev_hs && !VGA_HS) begin
      if (last_hs_fall >= 0) check("hs_period", n - last_hs_fall, 2 * HT);
      last_hs_fall = n;
    end
    prev_hs = VGA_HS;
    if (!VGA_VS) vs_low++;
    else if (vs_low != 0) begin check("vs_width", vs_low, 2 * VSW * HT); vs_low = 0; end
    if (VGA_BLANK_N) blank_hi++;
    else if (blank_hi != 0) begin check("blank_width", blank_hi, 2 * HA); blank_hi = 0; end
    if (VGA_R == 10'h3FF) red_cycles++;
    if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
  endtask

  task automatic release_reset();
    rst = 1'b1; rand_data = 1'b0; n = 0;
    fs_count = 0; last_fs = -1; hs_low = 0; blank_hi = 0; vs_low = 0;
    last_hs_fall = -1; prev_hs = 1'b1; red_cycles = 0; max_addr = 0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      check_cycle();
      measure();
    end
  endtask

  initial begin
    int extra;
    for (int i = 0; i < 19200; i++) mem[i] = 3'b0;
    mem[162] = 3'b101;

    // Held in reset with random read data: everything at reset values.
    repeat (4) begin @(posedge clk); @(negedge clk); check_reset(); end

    // Three frames of the single-pixel pattern.
    release_reset();
    check_cycle();
    run(3 * 2 * FRAME_PIX);
    check("fs_count_3frames", fs_count, 3);
    check("red_cycles", red_cycles, 3 * 16 * 2);
    check("max_addr", 32'(max_addr <= 19199), 1);

    // Run into line 30, then assert reset asynchronously mid-cycle.
    extra = int'($urandom_range(0, 2 * HA));
    run(2 * 30 * HT + extra);
    #2 rst = 1'b0;
    rand_data = 1'b1;
    #1 check_reset();
    for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom);
    repeat (3) begin @(posedge clk); @(negedge clk); check_reset(); end

    // Restart from (0,0) with random framebuffer contents.
    release_reset();
    check_cycle();
    run(2 * FRAME_PIX + 2 * HT);
    check("fs_count_after_reset", fs_count, 1);
    check("max_addr_after_reset", 32'(max_addr <= 19199), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Read side of the 160x120, 3-bit-per-pixel framebuffer that the game FSM writes with x/y/colour/plot. It generates 640x480@60 VGA timing from the 50 MHz board clock and fetches each framebuffer pixel through a synchronous read port. Each stored pixel is upscaled 4x in both directions and driven onto the VGA DAC pins. It also produces the once-per-frame tick that the game FSM uses to pace its IDLE→ERASE_PADDLE update loop, replacing a free-running divider.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); line total 800
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); frame total 525

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous, active-low reset
- rd_addr  out  15  framebuffer read address, y*160+x
- rd_data  in  3  framebuffer data {R,G,B}, valid one clk after rd_addr
- VGA_CLK  out  1  25 MHz pixel clock to DAC
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high during active video
- VGA_SYNC_N  out  1  constant 1
- VGA_R, VGA_G, VGA_B  out  10 each  DAC colour
- frame_start  out  1  one-clk pulse at start of vertical blanking

## Operation
- VGA_CLK is a toggle register. Define pix_en = VGA_CLK. Counters and all VGA output registers update only on clk edges where pix_en=1, i.e. where VGA_CLK falls. The DAC samples on the VGA_CLK rising edge, mid-pixel.
- hcount runs 0..799 and wraps to 0. vcount increments on the hcount 799→0 wrap and runs 0..524, wrapping to 0.
- active = (hcount<640) && (vcount<480).
- Address: x = hcount[9:2], y = vcount[8:2]. rd_addr = (y<<7)+(y<<5)+x, combinational from the counters, 15 bits, maximum 19199. Outside the active region rd_addr = 0.
- The memory registers rd_data on the following pix_en=0 edge.
- On the next pix_en=1 edge the output registers capture:
  - VGA_R = {10{rd_data[2]}}, VGA_G = {10{rd_data[1]}}, VGA_B = {10{rd_data[0]}} when the previous counter position was active; otherwise all zero.
  - VGA_HS = ~(656 <= hcount <= 751) and VGA_VS = ~(490 <= vcount <= 491), computed from the same previous counter values.
  - VGA_BLANK_N = active.
- All pins are therefore aligned and lag the counters by exactly one pixel period (2 clk).
- frame_start pulses high for exactly one clk, on the cycle immediately after the counters step to (h=0, v=480). No other cycle asserts it.
- The block has no state machine beyond the counters. No backpressure: rd_data is consumed unconditionally every pixel.

## Timing
- Reset (rst=0, asynchronous) forces: VGA_CLK=0, hcount=vcount=0, rd_addr=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, frame_start=0. VGA_SYNC_N is always 1.
- First edge after reset release: VGA_CLK 0→1, counters hold.
- Second edge: counters advance to h=1 and the outputs present pixel (0,0).
- Pipeline latency from the counter value to its pins is 2 clk.
- Line = 1600 clk; frame = 840000 clk (59.52 Hz). frame_start period is exactly 840000 clk.
- Reset asserted mid-frame returns everything to reset values immediately. After release, timing restarts from (0,0) with no partial pulses and no frame_start until v=480 is reached.

## Test plan
- Hold rst=0 with random rd_data → all outputs at reset values. Release rst → VGA_CLK toggles every clk, and the first VGA_CLK falling edge is 2 clk after release.
- Memory model preloaded with addr 162 = 3'b101 (x=2, y=1), all other addresses 0 → RGB = 3FF/000/3FF exactly for pixels h=8..11 on lines v=4..7, and zero everywhere else.
- Measure VGA_HS → low for 96 pixels (192 clk), falling edge 656 pixels after the line's first active pixel, period 1600 clk. VGA_BLANK_N high for exactly 640 pixels per active line.
- Measure VGA_VS → low for 2 lines (3200 clk), period 840000 clk. VGA_BLANK_N stays low throughout lines 480..524.
- Count frame_start over 3 frames → 3 one-clk pulses, spaced 840000 clk, each with vcount=480 and hcount=0 at that cycle.
- Assert rst for 3 clk at v=300 → outputs reset asynchronously. After release, the next frame_start arrives 480*1600 clk later (plus the 1-clk pipeline offset) and rd_addr never exceeds 19199.
